// File: rtl/normalize_pack.sv
// Floating-point adder back end: normalizes the raw adder mantissa, rounds and packs {sign, exp, frac}.
// Optional round-up on sticky is enabled by defining NORMALIZE_PACK_ROUND_EN (default: truncate).
module normalize_pack #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sign,
  input  logic [EXP_W-1:0]       in_exp,
  input  logic [MAN_W:0]         in_mant,
  input  logic                   in_carry,
  input  logic                   in_sticky,
  input  logic                   in_eff_sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_result,
  output logic [2:0]             out_flags,
  output logic [1:0]             dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // out_valid and its payload stay unchanged until that edge, and ready never depends on valid.

  typedef enum logic [1:0] {IDLE, NORM, ROUND, OUT} state_t;

  localparam logic [EXP_W:0] EXP_ONE = 1;
  localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

  state_t               state;
  logic                 sign_q;
  logic                 sticky_q;
  logic [EXP_W:0]       exp_q;
  logic [MAN_W:0]       mant_q;
  logic [EXP_W+MAN_W:0] res_q;
  logic [2:0]           flags_q;

  logic [MAN_W:0]       round_mant;
  logic [EXP_W:0]       round_exp;
  logic                 ovf;
  logic                 unf;
  logic [EXP_W+MAN_W:0] pack_res;
  logic [2:0]           pack_flags;
`ifdef NORMALIZE_PACK_ROUND_EN
  logic [MAN_W+1:0]     round_sum;
`endif

  assign in_ready  = (state == IDLE);
  assign dbg_state = state;

  // Rounding and packing of the normalized mantissa; consumed in the ROUND state.
  always_comb begin
    round_mant = mant_q;
    round_exp  = exp_q;
`ifdef NORMALIZE_PACK_ROUND_EN
    round_sum  = {1'b0, mant_q} + {{(MAN_W+1){1'b0}}, 1'b1};
    if (sticky_q && mant_q[0]) begin
      if (round_sum[MAN_W+1]) begin
        round_mant = round_sum[MAN_W+1:1];
        round_exp  = exp_q + EXP_ONE;
      end else begin
        round_mant = round_sum[MAN_W:0];
      end
    end
`endif
    ovf = (round_exp >= EXP_MAX);
    unf = !round_mant[MAN_W];
    if (ovf)
      pack_res = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else if (unf)
      pack_res = {sign_q, {EXP_W{1'b0}}, round_mant[MAN_W-1:0]};
    else
      pack_res = {sign_q, round_exp[EXP_W-1:0], round_mant[MAN_W-1:0]};
    pack_flags = {ovf, unf & ~ovf, sticky_q | ovf};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sign_q     <= 1'b0;
      sticky_q   <= 1'b0;
      exp_q      <= '0;
      mant_q     <= '0;
      res_q      <= '0;
      flags_q    <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sticky_q <= in_sticky;
            exp_q    <= (!in_eff_sub && in_carry) ? ({1'b0, in_exp} + EXP_ONE) : {1'b0, in_exp};
            // An effective subtract without carry produced a negative mantissa.
            if (in_eff_sub && !in_carry) begin
              mant_q <= -in_mant;
              sign_q <= ~in_sign;
            end else begin
              mant_q <= in_mant;
              sign_q <= in_sign;
            end
            state <= NORM;
          end
        end
        NORM: begin
          if (mant_q == '0) begin
            res_q   <= '0;
            flags_q <= {2'b00, sticky_q};
            state   <= OUT;
          end else if (!mant_q[MAN_W] && (exp_q > EXP_ONE)) begin
            mant_q <= mant_q << 1;
            exp_q  <= exp_q - EXP_ONE;
          end else begin
            state <= ROUND;
          end
        end
        ROUND: begin
          res_q   <= pack_res;
          flags_q <= pack_flags;
          state   <= OUT;
        end
        OUT: begin
          // First OUT cycle publishes the result; later cycles wait for the consumer.
          if (!out_valid) begin
            out_valid  <= 1'b1;
            out_result <= res_q;
            out_flags  <= flags_q;
          end else if (out_ready) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_normalize_pack.sv
// Directed bench for normalize_pack: hand-computed vectors checked with immediate assertions.
module tb_normalize_pack;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [4:0]  in_exp;
  logic [10:0] in_mant;
  logic        in_carry;
  logic        in_sticky;
  logic        in_eff_sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [2:0]  out_flags;
  logic [1:0]  dbg_state;

  int vec_cnt = 0;
  int err_cnt = 0;

  normalize_pack #(.EXP_W(5), .MAN_W(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .in_carry(in_carry), .in_sticky(in_sticky), .in_eff_sub(in_eff_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags),
    .dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents one input at a negedge and returns just after the accepting edge.
  task automatic accept(input string tag, input logic s, input logic [4:0] e, input logic [10:0] m,
                        input logic c, input logic st, input logic es);
    @(negedge clk);
    in_sign = s; in_exp = e; in_mant = m; in_carry = c; in_sticky = st; in_eff_sub = es;
    in_valid = 1'b1;
    check({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid rises (bounded).
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_vec(input string tag, input logic s, input logic [4:0] e, input logic [10:0] m,
                         input logic c, input logic st, input logic es,
                         input int exp_lat, input logic [15:0] exp_res, input logic [2:0] exp_fl);
    int lat;
    accept(tag, s, e, m, c, st, es);
    wait_valid(lat);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_result"}, out_result, exp_res);
    check({tag, "_flags"}, out_flags, exp_fl);
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_drain_valid"}, out_valid, 0);
    check({tag, "_drain_result"}, out_result, 0);
    check({tag, "_drain_flags"}, out_flags, 0);
  endtask

  initial begin
    int lat;
    logic saw_valid;
    rst_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0;
    in_carry = 1'b0; in_sticky = 1'b0; in_eff_sub = 1'b0; out_ready = 1'b1;

    // Reset state
    #3;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_flags", out_flags, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1.0 + 1.0 = 2.0: carry bumps exponent, no shifts
    run_vec("add_carry", 1'b0, 5'd15, 11'h400, 1'b1, 1'b0, 1'b0, 3, 16'h4000, 3'b000);
    drain("add_carry");

    // Deep cancellation: ten left shifts, exp 15 -> 5
    run_vec("cancel10", 1'b0, 5'd15, 11'h001, 1'b1, 1'b0, 1'b1, 13, 16'h1400, 3'b000);
    drain("cancel10");

    // Exact zero after subtract: +0 regardless of sign, short path
    run_vec("zero", 1'b1, 5'd15, 11'h000, 1'b1, 1'b0, 1'b1, 2, 16'h0000, 3'b000);
    drain("zero");

    // Exponent reaches 31: infinity with overflow and inexact
    run_vec("overflow", 1'b0, 5'd30, 11'h400, 1'b1, 1'b0, 1'b0, 3, 16'h7C00, 3'b101);
    drain("overflow");

    // All-ones mantissa with sticky: round-up carries into exponent, or truncates
`ifdef NORMALIZE_PACK_ROUND_EN
    run_vec("round", 1'b0, 5'd15, 11'h7FF, 1'b0, 1'b1, 1'b0, 3, 16'h4000, 3'b001);
`else
    run_vec("round", 1'b0, 5'd15, 11'h7FF, 1'b0, 1'b1, 1'b0, 3, 16'h3FFF, 3'b001);
`endif
    drain("round");

    // Negative subtract result: -0x7FE = 0x002, sign flips, 9 shifts, exp 15 -> 6
    run_vec("negate", 1'b0, 5'd15, 11'h7FE, 1'b0, 1'b0, 1'b1, 12, 16'h9800, 3'b000);
    drain("negate");

    // Exponent floor: two shifts then subnormal pack with underflow
    run_vec("subnormal", 1'b0, 5'd3, 11'h010, 1'b0, 1'b0, 1'b0, 5, 16'h0040, 3'b010);
    drain("subnormal");

    // Back-pressure: result and in_ready held while out_ready is low
    out_ready = 1'b0;
    run_vec("stall", 1'b1, 5'd15, 11'h400, 1'b1, 1'b0, 1'b0, 3, 16'hC000, 3'b000);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("stall_valid", out_valid, 1);
      check("stall_result", out_result, 16'hC000);
      check("stall_in_ready", in_ready, 0);
    end
    drain("stall");
    check("stall_idle_in_ready", in_ready, 1);

    // Reset during NORM: operation discarded, no output afterwards
    accept("abort", 1'b0, 5'd15, 11'h001, 1'b1, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("abort_in_norm", dbg_state, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_rst_in_ready", in_ready, 1);
    check("abort_rst_out_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) saw_valid = 1'b1;
    end
    check("abort_no_output", saw_valid, 0);

    // Block still operates after the aborted transaction
    run_vec("post_abort", 1'b0, 5'd15, 11'h400, 1'b1, 1'b0, 1'b0, 3, 16'h4000, 3'b000);
    drain("post_abort");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/normalize_pack.md
NORMALIZE_PACK -- requirements
Module: normalize_pack

Interface
REQ-001 SHALL have parameter EXP_W, default 5, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 10, stored fraction width; the datapath mantissa is MAN_W+1 bits including the hidden bit.
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  the adder result is presented.
REQ-006 SHALL have port in_ready  output  1  the block can accept an input.
REQ-007 SHALL have port in_sign  input  1  sign of the larger-magnitude operand.
REQ-008 SHALL have port in_exp  input  EXP_W  biased exponent of the larger operand.
REQ-009 SHALL have port in_mant  input  MAN_W+1  adder mantissa result, hidden bit at the MSB.
REQ-010 SHALL have port in_carry  input  1  adder carry: mantissa already right-shifted when the add is effective; result non-negative when the subtract is effective.
REQ-011 SHALL have port in_sticky  input  1  alignment bits were lost.
REQ-012 SHALL have port in_eff_sub  input  1  operand signs differ.
REQ-013 SHALL have port out_valid  output  1  a packed result is held.
REQ-014 SHALL have port out_ready  input  1  the downstream stage accepts the result.
REQ-015 SHALL have port out_result  output  1+EXP_W+MAN_W  packed word {sign, exp, frac}.
REQ-016 SHALL have port out_flags  output  3  {overflow, underflow, inexact}.

Function
REQ-017 SHALL use FSM states IDLE, NORM, ROUND, OUT, with in_ready=1 only in IDLE.
REQ-018 SHALL, on in_valid&&in_ready, capture all in_* fields and move to NORM.
REQ-019 SHALL set exp=in_exp+1 at capture when in_eff_sub=0 and in_carry=1; otherwise exp=in_exp.
REQ-020 SHALL, when in_eff_sub=1 and in_carry=0, capture the mantissa as its (MAN_W+1)-bit two's-complement negation and invert the sign.
REQ-021 SHALL, in NORM with mantissa 0, form +0 (all bits 0) and go directly to OUT.
REQ-022 SHALL, in NORM with MSB=0 and exp>1, shift the mantissa left 1 bit and decrement exp, one step per cycle.
REQ-023 SHALL leave NORM for ROUND when MSB=1 or exp<=1.
REQ-024 SHALL, if MSB=0 at exit, pack exp field 0 (subnormal) and set underflow.
REQ-025 SHALL complete ROUND in 1 cycle and enter OUT; rounding behaviour is in Configuration.
REQ-026 SHALL, when exp>=2^EXP_W-1 after ROUND, output infinity (exp all ones, frac 0) and set overflow.
REQ-027 SHALL set inexact=in_sticky, and also when overflow occurs.
REQ-028 SHALL assert out_valid exactly 3+k cycles after the accept edge, where k = number of NORM shifts (maximum MAN_W); the zero path takes 2 cycles.
REQ-029 SHALL hold out_valid, out_result and out_flags stable in OUT until out_ready=1, then return to IDLE on that edge.
REQ-030 SHALL keep out_result and out_flags 0 whenever out_valid=0.

Reset
REQ-031 SHALL, with rst_n=0, immediately force state IDLE, in_ready=1, out_valid=0, out_result=0 and out_flags=0.
REQ-032 SHALL, on reset mid-operation in any state, discard the operation and emit no output after release.

Configuration
REQ-033 SHALL, with NORMALIZE_PACK_ROUND_EN defined, increment the mantissa in ROUND when in_sticky=1 and LSB=1; on mantissa overflow it SHALL shift right 1 and increment exp.
REQ-034 SHALL, without NORMALIZE_PACK_ROUND_EN, truncate in ROUND (mantissa unchanged) while still taking the 1 cycle.

Verification
REQ-035 SHALL cover: exp=15, mant=0x400, carry=1, eff_sub=0, sign=0 -> out_result=0x4000, flags=000, out_valid 3 cycles after accept.
REQ-036 SHALL cover: exp=15, mant=0x001, carry=1, eff_sub=1 -> 10 shifts, out_result=0x1400, out_valid 13 cycles after accept.
REQ-037 SHALL cover: mant=0x000, eff_sub=1, carry=1, sign=1 -> out_result=0x0000, flags=000, out_valid 2 cycles after accept.
REQ-038 SHALL cover: exp=30, mant=0x400, carry=1, eff_sub=0 -> out_result=0x7C00, flags=101.
REQ-039 SHALL cover: exp=15, mant=0x7FF, sticky=1, carry=0, eff_sub=0 -> with ROUND_EN out_result=0x4000, without it 0x3FFF; flags=001 in both cases.
REQ-040 SHALL cover: out_ready low for 5 cycles in OUT -> out_result stable, in_ready=0; rst_n pulse during NORM -> out_valid never rises.
